// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, frame classification, debounce and strobe generation.
// Optional auto-repeat of the held key is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned STROBE_LEN    = 100,
  parameter int unsigned REPEAT_FRAMES = 2000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic       kbstrobe,
  output logic       keyup
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam int unsigned STB_W = $clog2(STROBE_LEN + 1);

  typedef enum logic {DRIVE, SAMPLE} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [1:0]         acc_cnt_q, acc_cnt_d;
  logic [3:0]         acc_code_q, acc_code_d;
  logic [4:0]         prev_res_q, prev_res_d;
  logic [DB_W-1:0]    stable_q, stable_d;
  logic [3:0]         hex0_q, hex0_d;
  logic               keyup_q, keyup_d;
  logic [STB_W-1:0]   strobe_cnt_q, strobe_cnt_d;

  logic [3:0] active;
  logic [2:0] hits, sum;
  logic [1:0] row_idx, base_cnt, new_cnt;
  logic [3:0] base_code, new_code;
  logic [4:0] res;
  logic       frame_end, same, accept, changed, start;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  function automatic logic [3:0] key_code(input logic [3:0] rc);
    logic [3:0] code;
    case (rc)
      4'd0:  code = 4'h1;  4'd1:  code = 4'h2;  4'd2:  code = 4'h3;  4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;  4'd5:  code = 4'h5;  4'd6:  code = 4'h6;  4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;  4'd9:  code = 4'h8;  4'd10: code = 4'h9;  4'd11: code = 4'hC;
      4'd12: code = 4'hE;  4'd13: code = 4'h0;  4'd14: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    col_idx_d    = col_idx_q;
    acc_cnt_d    = acc_cnt_q;
    acc_code_d   = acc_code_q;
    prev_res_d   = prev_res_q;
    stable_d     = stable_q;
    hex0_d       = hex0_q;
    keyup_d      = keyup_q;
    strobe_cnt_d = strobe_cnt_q;
    active       = ~row;
    hits         = 3'(active[0]) + 3'(active[1]) + 3'(active[2]) + 3'(active[3]);
    row_idx      = '0;
    base_cnt     = '0;
    base_code    = '0;
    sum          = '0;
    new_cnt      = '0;
    new_code     = '0;
    res          = '0;
    frame_end    = 1'b0;
    same         = 1'b0;
    accept       = 1'b0;
    changed      = 1'b0;
    start        = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d    = rep_cnt_q;
`endif

    for (int unsigned i = 0; i < 4; i++) begin
      if (active[i]) row_idx = 2'(i);
    end

    case (state_q)
      DRIVE: begin
        if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
          state_d   = SAMPLE;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d   = DRIVE;
        col_idx_d = col_idx_q + 2'd1;
        // Column 0 opens a fresh frame; the hit count saturates at 2 (MULTI)
        base_cnt  = (col_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
        base_code = (col_idx_q == 2'd0) ? 4'h0 : acc_code_q;
        sum       = 3'(base_cnt) + hits;
        new_cnt   = (sum > 3'd2) ? 2'd2 : sum[1:0];
        new_code  = (hits == 3'd1) ? key_code({row_idx, col_idx_q}) : base_code;
        acc_cnt_d  = new_cnt;
        acc_code_d = new_code;
        if (col_idx_q == 2'd3) begin
          frame_end = 1'b1;
          res       = (new_cnt == 2'd1) ? {1'b1, new_code} : 5'd0;
        end
      end
    endcase

    if (frame_end) begin
      prev_res_d = res;
      same       = (res == prev_res_q);
      if (same) begin
        stable_d = (stable_q == DB_W'(DEBOUNCE)) ? stable_q : stable_q + DB_W'(1);
      end else begin
        stable_d = DB_W'(1);
      end
      accept = (stable_d == DB_W'(DEBOUNCE)) && !(same && (stable_q == DB_W'(DEBOUNCE)));
      if (accept) begin
        if (res[4]) begin
          if (!keyup_q || (hex0_q != res[3:0])) begin
            hex0_d  = res[3:0];
            keyup_d = 1'b1;
            start   = 1'b1;
            changed = 1'b1;
          end
        end else if (keyup_q) begin
          keyup_d = 1'b0;
          changed = 1'b1;
        end
      end
`ifdef KEYPAD_REPEAT_EN
      if (changed || !keyup_q) begin
        rep_cnt_d = '0;
      end else if (rep_cnt_q == REP_W'(REPEAT_FRAMES - 1)) begin
        rep_cnt_d = '0;
        start     = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
`endif
    end

    if (strobe_cnt_q != '0) strobe_cnt_d = strobe_cnt_q - STB_W'(1);
    if (start) strobe_cnt_d = STB_W'(STROBE_LEN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= DRIVE;
      div_cnt_q    <= '0;
      col_idx_q    <= '0;
      acc_cnt_q    <= '0;
      acc_code_q   <= '0;
      prev_res_q   <= '0;
      stable_q     <= '0;
      hex0_q       <= '0;
      keyup_q      <= 1'b0;
      strobe_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      col_idx_q    <= col_idx_d;
      acc_cnt_q    <= acc_cnt_d;
      acc_code_q   <= acc_code_d;
      prev_res_q   <= prev_res_d;
      stable_q     <= stable_d;
      hex0_q       <= hex0_d;
      keyup_q      <= keyup_d;
      strobe_cnt_q <= strobe_cnt_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge CLK) begin
    if (RST) rep_cnt_q <= '0;
    else     rep_cnt_q <= rep_cnt_d;
  end
`endif

  assign col      = ~(4'b0001 << col_idx_q);
  assign hex1     = '0;
  assign hex0     = hex0_q;
  assign keyup    = keyup_q;
  assign kbstrobe = (strobe_cnt_q != '0);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a switch-matrix model drives row from col and a pressed-key mask.
module tb_keypad_scanner;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] pressed = '0;   // bit r*4+c
  logic [3:0]  row_m;
  logic [3:0]  col, hex1, hex0;
  logic        kbstrobe, keyup;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobes = 0;
  int cur_w = 0;
  int last_w = 0;
  int n_unstable = 0;
  logic       prev_stb = 1'b0;
  logic [3:0] stb_hex = '0;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE(2),
    .STROBE_LEN(3),
    .REPEAT_FRAMES(5)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .row(row_m),
    .col(col),
    .hex1(hex1),
    .hex0(hex0),
    .kbstrobe(kbstrobe),
    .keyup(keyup)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    row_m = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (|(pressed[r*4 +: 4] & ~col)) row_m[r] = 1'b0;
    end
  end

  // Strobe monitor: counts pulses, measures width, flags hex0 moving under a strobe
  always begin
    @(posedge CLK);
    #1;
    if (RST) begin
      n_strobes = 0;
      last_w    = 0;
      cur_w     = 0;
      prev_stb  = 1'b0;
    end else begin
      if (kbstrobe && !prev_stb) begin
        n_strobes++;
        stb_hex = hex0;
        cur_w   = 1;
      end else if (kbstrobe) begin
        cur_w++;
        if (hex0 != stb_hex) n_unstable++;
      end else if (prev_stb) begin
        last_w = cur_w;
      end
      prev_stb = kbstrobe;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Leaves the bench 2 time units after the last reset edge; the next edge starts scanning
  task automatic do_reset(input logic [15:0] keys);
    RST = 1'b1;
    pressed = '0;
    tick(3);
    pressed = keys;
    RST = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_col;
    int exp_rep, exp_final;

    tick(1);
    check_eq("rst_col", 32'(col), 32'hE);
    check_eq("rst_hex0", 32'(hex0), 32'h0);
    check_eq("rst_hex1", 32'(hex1), 32'h0);
    check_eq("rst_stb", 32'(kbstrobe), 32'h0);
    check_eq("rst_keyup", 32'(keyup), 32'h0);

    // Idle scan: each column held SCAN_DIV+1 cycles, order 0..3
    do_reset('0);
    tick(2);
    for (int j = 0; j < 40; j++) begin
      exp_col = ~(4'b0001 << (j % 4));
      check_eq("idle_col", 32'(col), 32'(exp_col));
      tick(5);
    end
    check_eq("idle_strobes", 32'(n_strobes), 32'd0);
    check_eq("idle_keyup", 32'(keyup), 32'h0);
    check_eq("idle_hex0", 32'(hex0), 32'h0);

    // Key "2" (r0,c1) held from scan start: accepted at end of frame 2
    do_reset(16'h0002);
    tick(38);
    check_eq("k2_early", 32'(n_strobes), 32'd0);
    tick(2);
    check_eq("k2_stb", 32'(kbstrobe), 32'h1);
    check_eq("k2_hex0", 32'(hex0), 32'h2);
    check_eq("k2_keyup", 32'(keyup), 32'h1);
    tick(20);
    check_eq("k2_count", 32'(n_strobes), 32'd1);
    check_eq("k2_width", 32'(last_w), 32'd3);
    check_eq("k2_hex1", 32'(hex1), 32'h0);
    pressed = '0;
    tick(19);
    check_eq("k2_rel_hold", 32'(keyup), 32'h1);
    tick(21);
    check_eq("k2_rel_keyup", 32'(keyup), 32'h0);
    check_eq("k2_rel_hex0", 32'(hex0), 32'h2);
    check_eq("k2_rel_count", 32'(n_strobes), 32'd1);

    // Key "8" (r2,c1) bounces on alternate frames, then held
    do_reset('0);
    for (int f = 0; f < 6; f++) begin
      pressed[9] = (f % 2 == 1);
      tick(20);
    end
    check_eq("k8_bounce_cnt", 32'(n_strobes), 32'd0);
    check_eq("k8_bounce_keyup", 32'(keyup), 32'h0);
    pressed[9] = 1'b1;
    tick(40);
    check_eq("k8_count", 32'(n_strobes), 32'd1);
    check_eq("k8_hex0", 32'(hex0), 32'h8);
    check_eq("k8_keyup", 32'(keyup), 32'h1);

    // "4" (r1,c0) and "6" (r1,c2) together are MULTI, then "6" released
    do_reset(16'h0050);
    tick(80);
    check_eq("multi_keyup", 32'(keyup), 32'h0);
    check_eq("multi_count", 32'(n_strobes), 32'd0);
    check_eq("multi_hex0", 32'(hex0), 32'h0);
    pressed[6] = 1'b0;
    tick(45);
    check_eq("k4_count", 32'(n_strobes), 32'd1);
    check_eq("k4_hex0", 32'(hex0), 32'h4);
    check_eq("k4_keyup", 32'(keyup), 32'h1);

    // "6" held, reset asserted mid-frame while its strobe is in flight
    do_reset(16'h0040);
    tick(41);
    check_eq("k6_pre_stb", 32'(kbstrobe), 32'h1);
    check_eq("k6_pre_hex0", 32'(hex0), 32'h6);
    RST = 1'b1;
    tick(1);
    check_eq("k6_rst_col", 32'(col), 32'hE);
    check_eq("k6_rst_hex0", 32'(hex0), 32'h0);
    check_eq("k6_rst_hex1", 32'(hex1), 32'h0);
    check_eq("k6_rst_stb", 32'(kbstrobe), 32'h0);
    check_eq("k6_rst_keyup", 32'(keyup), 32'h0);
    tick(2);
    RST = 1'b0;
    tick(38);
    check_eq("k6_post_early", 32'(n_strobes), 32'd0);
    tick(7);
    check_eq("k6_post_count", 32'(n_strobes), 32'd1);
    check_eq("k6_post_hex0", 32'(hex0), 32'h6);
    check_eq("k6_post_keyup", 32'(keyup), 32'h1);

    // "2" held 16 frames, then switched directly to "5" (r1,c1)
`ifdef KEYPAD_REPEAT_EN
    exp_rep   = 3;
    exp_final = 5;
`else
    exp_rep   = 1;
    exp_final = 2;
`endif
    do_reset(16'h0002);
    tick(325);
    check_eq("rep_count", 32'(n_strobes), 32'(exp_rep));
    check_eq("rep_hex0", 32'(hex0), 32'h2);
    pressed = 16'h0020;
    tick(25);
    check_eq("chg_keyup_mid", 32'(keyup), 32'h1);
    tick(20);
    check_eq("chg_count", 32'(n_strobes), 32'(exp_final));
    check_eq("chg_hex0", 32'(hex0), 32'h5);
    check_eq("chg_keyup", 32'(keyup), 32'h1);
    check_eq("hex0_stable_under_stb", 32'(n_unstable), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 1000: CLK cycles each column is driven before its rows are sampled.
REQ-002 SHALL provide parameter DEBOUNCE, default 4: consecutive identical scan frames required to accept a new key state.
REQ-003 SHALL provide parameter STROBE_LEN, default 100: kbstrobe width in CLK cycles, so the 1 MHz player domain cannot miss it.
REQ-004 SHALL provide parameter REPEAT_FRAMES, default 2000: frames between repeat strobes (used only with the REQ-022 macro).
REQ-005 CLK  input  1  system clock; the only clock.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 row  input  4  keypad rows, active-low, externally pulled up.
REQ-008 col  output  4  keypad column drive, one-cold.
REQ-009 hex1  output  4  key code high nibble, always 4'h0.
REQ-010 hex0  output  4  key code low nibble.
REQ-011 kbstrobe  output  1  new-key pulse, STROBE_LEN cycles wide.
REQ-012 keyup  output  1  high while a debounced valid key is held.

Function
REQ-013 SHALL scan with FSM states DRIVE and SAMPLE:
- DRIVE: col[c] low, other columns high, for SCAN_DIV cycles.
- SAMPLE: latch ~row for column c (one cycle), then c <= c+1 mod 4 and return to DRIVE.
- Sampling column 3 completes one frame.
REQ-014 SHALL map (row r, column c) to a code using the 4x4 layout:
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: E 0 F D (the * key is E, the # key is F)
REQ-015 SHALL classify each frame result as NONE (zero active bits), KEY(code) (exactly one active bit) or MULTI (two or more active bits); MULTI is treated as NONE.
REQ-016 SHALL debounce frames:
- A frame result equal to the previous frame result increments stable_cnt, saturating at DEBOUNCE.
- A different result sets stable_cnt to 1.
- The result is accepted when stable_cnt first reaches DEBOUNCE.
REQ-017 SHALL, when NONE->KEY(k) is accepted:
- set hex0 <= k and keyup <= 1;
- start kbstrobe in the same cycle as the hex0 update.
REQ-018 SHALL, when KEY(k)->KEY(j) with j != k is accepted, update hex0 <= j and restart kbstrobe; keyup stays 1.
REQ-019 SHALL, when KEY->NONE is accepted, set keyup <= 0, hold hex0 and leave kbstrobe unaffected.
REQ-020 SHALL keep hex1 == 4'h0, and keep hex0 stable for the entire time kbstrobe is high.
REQ-021 SHALL, if a new strobe is started while kbstrobe is high, reload the width counter so kbstrobe stays continuously high for STROBE_LEN cycles from the new event.

Configuration
REQ-022 SHALL implement auto-repeat only when macro KEYPAD_REPEAT_EN is defined:
- While keyup=1 with the same key, kbstrobe is re-issued every REPEAT_FRAMES frames.
- The repeat frame counter clears on any accepted state change.
- Without the macro, exactly one strobe is issued per accepted press and no repeat counter is synthesised.

Reset
REQ-023 SHALL, while RST=1 at a CLK edge, set:
- col=4'b1110, column index 0, state DRIVE;
- hex1=0, hex0=0, kbstrobe=0, keyup=0;
- all counters to 0 and the previous-frame result to NONE.
REQ-024 SHALL discard any partial frame, debounce history and in-flight strobe when RST asserts mid-operation.
REQ-025 SHALL begin scanning on the first CLK edge after RST deasserts and issue no strobe for a key already held; that key is accepted after DEBOUNCE frames like any other.

Verification (SCAN_DIV=4, DEBOUNCE=2, STROBE_LEN=3, REPEAT_FRAMES=5)
REQ-026 Idle rows 4'hF for 10 frames -> col cycles 1110,1101,1011,0111; kbstrobe=0; keyup=0; hex0=0.
REQ-027 Key "2" (r0,c1) held continuously -> within 3 frames: hex0=4'h2, hex1=0, keyup=1, kbstrobe high exactly 3 cycles; released -> keyup=0 after 2 NONE frames and hex0 stays 2.
REQ-028 Key "8" bounces (present and absent on alternate frames) for 6 frames then held -> no strobe during bouncing; one strobe with hex0=4'h8 once the key is stable.
REQ-029 Keys "4" and "6" held together -> MULTI, keyup=0, no strobe; release "6" -> hex0=4'h4 with one strobe.
REQ-030 Key "6" held, RST pulsed mid-frame -> all outputs 0 next cycle; after release, strobe with hex0=4'h6 after 2 frames.
REQ-031 With KEYPAD_REPEAT_EN, key "2" held 16 frames -> initial strobe plus repeats every 5 frames; without the macro -> a single strobe.
